// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time, drives a single-port data memory, returns a response.
// Latency 2 cycles accept->resp (1 for misaligned); req_ready only in IDLE, response held until resp_ready.
module load_store_unit #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] mem_access_addr,
  output logic [15:0] mem_write_data,
  output logic        mem_write_en,
  output logic        mem_read,
  input  logic [15:0] mem_read_data,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_err;
  logic [7:0]  r_err_count;

  logic w_accept;
  logic w_misaligned;
  logic w_resp_hs;

  assign w_misaligned = ALIGN_CHECK && req_addr[0];
  assign w_accept     = req_valid && (r_state == IDLE);
  assign w_resp_hs    = (r_state == RESP) && resp_ready;

  always_comb begin
    w_next          = r_state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    mem_read        = 1'b0;
    mem_write_en    = 1'b0;
    mem_access_addr = 16'h0000;
    mem_write_data  = 16'h0000;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_misaligned) w_next = RESP;
          else if (req_we)  w_next = STORE;
          else              w_next = LOAD;
        end
      end
      LOAD: begin
        // Gating on r_we keeps read and write mutually exclusive by construction.
        mem_read        = !r_we;
        mem_access_addr = r_addr;
        w_next          = RESP;
      end
      STORE: begin
        mem_write_en    = r_we;
        mem_access_addr = r_addr;
        mem_write_data  = r_wdata;
        w_next          = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_addr      <= 16'h0000;
      r_wdata     <= 16'h0000;
      r_rdata     <= 16'h0000;
      r_err       <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_rdata <= 16'h0000;
        r_err   <= w_misaligned;
      end
      if (r_state == LOAD) r_rdata <= mem_read_data;
      if (w_resp_hs && r_err && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural data memory attached.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [15:0] mem_read_data;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rd    = 0;
  int n_wr    = 0;
  int n_both  = 0;

  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  load_store_unit #(.ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_read_data(mem_read_data), .err_count(err_count)
  );

  // Data memory: word array indexed by byte address, synchronous write, combinational read.
  assign mem_read_data = mem[mem_access_addr[8:1]];
  always @(posedge clk) if (mem_write_en) mem[mem_access_addr[8:1]] <= mem_write_data;

  always @(negedge clk) begin
    if (mem_read)                 n_rd   = n_rd + 1;
    if (mem_write_en)             n_wr   = n_wr + 1;
    if (mem_read && mem_write_en) n_both = n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // One request with resp_ready held high; reports latency, response and the memory-side view in the cycle after acceptance.
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        output int lat, output logic [15:0] rdata, output logic err,
                        output logic rd1, output logic wr1, output logic [15:0] a1, output logic [15:0] d1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    tick;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    rd1 = mem_read; wr1 = mem_write_en; a1 = mem_access_addr; d1 = mem_write_data;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      tick;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    tick;
  endtask

  int          lat;
  logic [15:0] rdata, a1, d1;
  logic        err, rd1, wr1;
  int          rd0, wr0;
  logic        bp_ok;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    resp_ready = 1'b1;
    tick; tick;
    rst = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_write_en}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_rdata", {16'd0, resp_rdata}, 32'd0);

    // Store 0x00A4 <- 0xBEEF
    wr0 = n_wr;
    do_req(1'b1, 16'h00A4, 16'hBEEF, lat, rdata, err, rd1, wr1, a1, d1);
    chk("st_lat", lat, 32'd2);
    chk("st_err", {31'd0, err}, 32'd0);
    chk("st_rdata", {16'd0, rdata}, 32'd0);
    chk("st_we", {31'd0, wr1}, 32'd1);
    chk("st_addr", {16'd0, a1}, 32'h00A4);
    chk("st_wdata", {16'd0, d1}, 32'hBEEF);
    chk("st_pulses", n_wr - wr0, 32'd1);
    chk("st_ready_after", {31'd0, req_ready}, 32'd1);

    // Load 0x00A4 -> 0xBEEF
    do_req(1'b0, 16'h00A4, 16'h0000, lat, rdata, err, rd1, wr1, a1, d1);
    chk("ld_lat", lat, 32'd2);
    chk("ld_rdata", {16'd0, rdata}, 32'hBEEF);
    chk("ld_err", {31'd0, err}, 32'd0);
    chk("ld_read", {31'd0, rd1}, 32'd1);
    chk("ld_addr", {16'd0, a1}, 32'h00A4);
    chk("ld_ready_after", {31'd0, req_ready}, 32'd1);

    // Misaligned load 0x0013
    rd0 = n_rd; wr0 = n_wr;
    do_req(1'b0, 16'h0013, 16'h0000, lat, rdata, err, rd1, wr1, a1, d1);
    chk("mis_err", {31'd0, err}, 32'd1);
    chk("mis_rdata", {16'd0, rdata}, 32'd0);
    chk("mis_no_rd", n_rd - rd0, 32'd0);
    chk("mis_no_wr", n_wr - wr0, 32'd0);
    chk("mis_err_count", {24'd0, err_count}, 32'd1);

    // Backpressure on a load response
    do_req(1'b1, 16'h0010, 16'h1234, lat, rdata, err, rd1, wr1, a1, d1);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
    tick;
    req_valid = 1'b0;
    tick;
    bp_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(resp_valid === 1'b1 && resp_rdata === 16'h1234 && resp_err === 1'b0 && req_ready === 1'b0))
        bp_ok = 1'b0;
      tick;
    end
    chk("bp_held", {31'd0, bp_ok}, 32'd1);
    chk("bp_rdata", {16'd0, resp_rdata}, 32'h1234);
    resp_ready = 1'b1;
    tick;
    chk("bp_released", {31'd0, resp_valid}, 32'd0);
    chk("bp_ready_back", {31'd0, req_ready}, 32'd1);

    // Saturation: err_count is 1 here
    for (int i = 1; i <= 260; i++) begin
      do_req(1'b1, 16'h0101, 16'hFFFF, lat, rdata, err, rd1, wr1, a1, d1);
      if (i == 100) chk("sat_mid", {24'd0, err_count}, 32'd101);
      if (i == 254) chk("sat_reach", {24'd0, err_count}, 32'd255);
    end
    chk("sat_final", {24'd0, err_count}, 32'd255);
    chk("sat_mem_untouched", {16'd0, mem[8'h80]}, 32'd0);

    // Reset while in LOAD
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h00A4;
    tick;
    req_valid = 1'b0;
    chk("rm_in_load", {31'd0, mem_read}, 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rm_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rm_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rm_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rm_err_count", {24'd0, err_count}, 32'd0);
    tick; tick;
    chk("rm_no_resp", {31'd0, resp_valid}, 32'd0);

    chk("never_rd_and_wr", n_both, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one parameter: ALIGN_CHECK, default 1; 1 enables the misaligned-address check, 0 disables it.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1 bit: core request valid.
REQ-005 SHALL have port req_ready, output, 1 bit: LSU can accept a request.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_addr, input, 16 bits: byte address.
REQ-008 SHALL have port req_wdata, input, 16 bits: store data.
REQ-009 SHALL have port resp_valid, output, 1 bit: response available.
REQ-010 SHALL have port resp_ready, input, 1 bit: core accepts the response.
REQ-011 SHALL have port resp_rdata, output, 16 bits: load data; 0 for stores and errors.
REQ-012 SHALL have port resp_err, output, 1 bit: request was rejected as misaligned.
REQ-013 SHALL have port mem_access_addr, output, 16 bits: to Data_Memory.
REQ-014 SHALL have port mem_write_data, output, 16 bits: to Data_Memory.
REQ-015 SHALL have port mem_write_en, output, 1 bit: to Data_Memory; write on clk edge.
REQ-016 SHALL have port mem_read, output, 1 bit: to Data_Memory; combinational read enable.
REQ-017 SHALL have port mem_read_data, input, 16 bits: from Data_Memory.
REQ-018 SHALL have port err_count, output, 8 bits: saturating count of error responses.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, STORE, RESP.
REQ-020 SHALL drive req_ready=1 only in IDLE.
- A request is accepted when req_valid && req_ready at a rising edge.
- req_addr, req_we and req_wdata SHALL be latched on acceptance.
REQ-021 SHALL treat an accepted request with ALIGN_CHECK=1 and req_addr[0]=1 as misaligned.
- Next state RESP with resp_err=1 and resp_rdata=0.
- No memory access: mem_read and mem_write_en stay 0.
REQ-022 SHALL, for an accepted aligned load, go IDLE->LOAD.
- In LOAD: mem_read=1, mem_access_addr=latched address.
- mem_read_data SHALL be captured into resp_rdata at the end of LOAD; next state RESP.
REQ-023 SHALL, for an accepted aligned store, go IDLE->STORE.
- In STORE: mem_write_en=1 for exactly one cycle, with mem_access_addr and mem_write_data = latched values.
- Next state RESP with resp_rdata=0.
REQ-024 SHALL assert resp_valid only in RESP.
- resp_rdata and resp_err SHALL hold stable until resp_valid && resp_ready.
- On that handshake the FSM SHALL return to IDLE.
REQ-025 SHALL give request acceptance to response a latency of 2 cycles (resp_valid on the 2nd edge after acceptance), and a minimum request-to-request spacing of 3 cycles when resp_ready is held at 1.
REQ-026 SHALL NOT accept a new request in the same cycle as a response handshake (req_ready=0 in RESP).
REQ-027 SHALL drive mem_read and mem_write_en to 0, and mem_access_addr and mem_write_data to 0, outside LOAD and STORE respectively.
REQ-028 SHALL never assert mem_read and mem_write_en in the same cycle.
REQ-029 SHALL increment err_count on each error response handshake, saturating at 255 with no wrap.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, force state IDLE and all outputs to 0 except req_ready.
- req_ready SHALL be 1 from the first cycle after reset.
- err_count SHALL be 0.
REQ-031 SHALL, if reset occurs mid-transaction (LOAD, STORE or RESP), abandon it with no response issued.
- A store already in STORE still sees mem_write_en for that cycle only if rst was 0 at the preceding edge.

Verification
REQ-032 Store then load: store 0x00A4 <- 0xBEEF, then load 0x00A4 -> one mem_write_en pulse; load response resp_rdata=0xBEEF, resp_err=0; each resp_valid 2 cycles after acceptance.
REQ-033 Misaligned: load at 0x0013 (ALIGN_CHECK=1) -> resp_err=1, resp_rdata=0, no mem_read/mem_write_en, err_count 0->1.
REQ-034 Backpressure: resp_ready=0 for 5 cycles during a load response -> resp_valid and resp_rdata held stable; req_ready=0 throughout.
REQ-035 Saturation: 260 misaligned requests -> err_count=255.
REQ-036 Reset mid-op: rst=1 while in LOAD -> next cycle req_ready=1, resp_valid=0, mem_read=0, err_count=0.
